// File: rtl/wavepool_instr_feeder.sv
// wavepool_instr_feeder: per-wavefront dword FIFOs feeding decode with half-request priority and round-robin issue.
// Optional issued-dword counter enabled by defining WAVEPOOL_FEEDER_PERF_EN.
module wavepool_instr_feeder #(
  parameter int NUM_WF = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [5:0]        fetch_wfid,
  input  logic [31:0]       fetch_instr,
  input  logic [31:0]       fetch_pc,
  input  logic              wf_init_en,
  input  logic [5:0]        wf_init_wfid,
  input  logic [8:0]        wf_init_sgpr_base,
  input  logic [9:0]        wf_init_vgpr_base,
  input  logic [15:0]       wf_init_lds_base,
  input  logic              issue_wf_done_en,
  input  logic [5:0]        issue_wf_done_wfid,
  input  logic              wave_ins_half_rqd,
  input  logic [5:0]        wave_ins_half_wfid,
  input  logic              issue_recover_en,
  input  logic [5:0]        issue_recover_wfid,
  output logic              wave_instr_valid,
  output logic [31:0]       wave_instr,
  output logic [31:0]       wave_instr_pc,
  output logic [5:0]        wave_wfid,
  output logic [8:0]        wave_sgpr_base,
  output logic [9:0]        wave_vgpr_base,
  output logic [15:0]       wave_lds_base,
  output logic [NUM_WF-1:0] wf_buf_full,
  output logic              overflow_err,
  output logic [31:0]       issued_cnt
);
  localparam int WW = $clog2(NUM_WF);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0] mem_q [NUM_WF][DEPTH];
  logic [PW-1:0] head_q [NUM_WF], head_d [NUM_WF], tail_q [NUM_WF], tail_d [NUM_WF];
  logic [CW-1:0] cnt_q [NUM_WF], cnt_d [NUM_WF];
  logic [8:0] sgpr_q [NUM_WF], sgpr_d [NUM_WF];
  logic [9:0] vgpr_q [NUM_WF], vgpr_d [NUM_WF];
  logic [15:0] lds_q [NUM_WF], lds_d [NUM_WF];
  logic [NUM_WF-1:0] blocked_q, blocked_d, half_q, half_d;
  logic [WW-1:0] last_q, last_d;
  logic ovf_q, ovf_d;
  logic [NUM_WF-1:0] fetch_hit, init_hit, done_hit, half_hit, rec_hit, push, pop, elig_n, elig_h;
  logic grant, grant_half, found_h, found_n;
  logic [WW-1:0] sel_h, sel_n, gsel;
  logic valid_q;
  logic [31:0] instr_q, pc_q;
  logic [5:0] wfid_q;
  logic [8:0] sgo_q;
  logic [9:0] vgo_q;
  logic [15:0] ldo_q;

  // Out-of-range wfids never match any slot, so they are ignored everywhere.
  always_comb begin
    for (int w = 0; w < NUM_WF; w++) begin
      fetch_hit[w]   = fetch_valid && fetch_wfid == 6'(w);
      init_hit[w]    = wf_init_en && wf_init_wfid == 6'(w);
      done_hit[w]    = issue_wf_done_en && issue_wf_done_wfid == 6'(w);
      half_hit[w]    = wave_ins_half_rqd && wave_ins_half_wfid == 6'(w);
      rec_hit[w]     = issue_recover_en && issue_recover_wfid == 6'(w);
      wf_buf_full[w] = cnt_q[w] == CW'(DEPTH);
      elig_n[w]      = cnt_q[w] != '0 && !blocked_q[w] && !rec_hit[w];
      elig_h[w]      = cnt_q[w] != '0 && half_q[w] && !rec_hit[w];
    end
  end

  // Descending scans leave the highest-priority candidate as the final assignment.
  always_comb begin
    found_h = 1'b0;
    sel_h   = '0;
    found_n = 1'b0;
    sel_n   = '0;
    for (int w = NUM_WF - 1; w >= 0; w--) begin
      if (elig_h[w]) begin
        found_h = 1'b1;
        sel_h   = WW'(w);
      end
    end
    for (int i = NUM_WF; i >= 1; i--) begin
      if (elig_n[WW'((int'(last_q) + i) % NUM_WF)]) begin
        found_n = 1'b1;
        sel_n   = WW'((int'(last_q) + i) % NUM_WF);
      end
    end
    grant      = found_h || found_n;
    grant_half = found_h;
    gsel       = found_h ? sel_h : sel_n;
  end

  always_comb begin
    for (int w = 0; w < NUM_WF; w++) begin
      push[w]      = fetch_hit[w] && !wf_buf_full[w] && !rec_hit[w];
      pop[w]       = grant && gsel == WW'(w);
      head_d[w]    = rec_hit[w] ? '0 : head_q[w] + PW'(pop[w]);
      tail_d[w]    = rec_hit[w] ? '0 : tail_q[w] + PW'(push[w]);
      cnt_d[w]     = rec_hit[w] ? '0 : cnt_q[w] + CW'(push[w]) - CW'(pop[w]);
      blocked_d[w] = rec_hit[w] || done_hit[w] ? 1'b0 : pop[w] && !grant_half ? 1'b1 : blocked_q[w];
      half_d[w]    = rec_hit[w] ? 1'b0 : half_hit[w] ? 1'b1 : pop[w] && grant_half ? 1'b0 : half_q[w];
      sgpr_d[w]    = init_hit[w] ? wf_init_sgpr_base : sgpr_q[w];
      vgpr_d[w]    = init_hit[w] ? wf_init_vgpr_base : vgpr_q[w];
      lds_d[w]     = init_hit[w] ? wf_init_lds_base : lds_q[w];
    end
    last_d = grant && !grant_half ? gsel : last_q;
    ovf_d  = ovf_q || |(fetch_hit & wf_buf_full);
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WF; w++)
      if (push[w]) mem_q[w][tail_q[w]] <= {fetch_instr, fetch_pc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '{default: '0};
      tail_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      sgpr_q    <= '{default: '0};
      vgpr_q    <= '{default: '0};
      lds_q     <= '{default: '0};
      blocked_q <= '0;
      half_q    <= '0;
      last_q    <= WW'(NUM_WF - 1);
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      wfid_q    <= '0;
      sgo_q     <= '0;
      vgo_q     <= '0;
      ldo_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      sgpr_q    <= sgpr_d;
      vgpr_q    <= vgpr_d;
      lds_q     <= lds_d;
      blocked_q <= blocked_d;
      half_q    <= half_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      valid_q   <= grant;
      if (grant) begin
        instr_q <= mem_q[gsel][head_q[gsel]][63:32];
        pc_q    <= mem_q[gsel][head_q[gsel]][31:0];
        wfid_q  <= 6'(gsel);
        sgo_q   <= sgpr_q[gsel];
        vgo_q   <= vgpr_q[gsel];
        ldo_q   <= lds_q[gsel];
      end
    end
  end

`ifdef WAVEPOOL_FEEDER_PERF_EN
  logic [31:0] issued_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) issued_q <= '0;
    else issued_q <= issued_q + 32'(valid_q);
  end
  assign issued_cnt = issued_q;
`else
  assign issued_cnt = '0;
`endif

  assign wave_instr_valid = valid_q;
  assign wave_instr       = instr_q;
  assign wave_instr_pc    = pc_q;
  assign wave_wfid        = wfid_q;
  assign wave_sgpr_base   = sgo_q;
  assign wave_vgpr_base   = vgo_q;
  assign wave_lds_base    = ldo_q;
  assign overflow_err     = ovf_q;
endmodule

// File: tb/tb_wavepool_instr_feeder.sv
// tb_wavepool_instr_feeder: directed scenarios plus random traffic checked against a queue-based model.
module tb_wavepool_instr_feeder;
  logic clk = 1'b0;
  logic rst;
  logic fetch_valid, wf_init_en, issue_wf_done_en, wave_ins_half_rqd, issue_recover_en;
  logic [5:0] fetch_wfid, wf_init_wfid, issue_wf_done_wfid, wave_ins_half_wfid, issue_recover_wfid;
  logic [31:0] fetch_instr, fetch_pc;
  logic [8:0] wf_init_sgpr_base;
  logic [9:0] wf_init_vgpr_base;
  logic [15:0] wf_init_lds_base;
  logic wave_instr_valid, overflow_err;
  logic [31:0] wave_instr, wave_instr_pc, issued_cnt;
  logic [5:0] wave_wfid;
  logic [8:0] wave_sgpr_base;
  logic [9:0] wave_vgpr_base;
  logic [15:0] wave_lds_base;
  logic [7:0] wf_buf_full;

  wavepool_instr_feeder dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_wfid(fetch_wfid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .wf_init_en(wf_init_en), .wf_init_wfid(wf_init_wfid), .wf_init_sgpr_base(wf_init_sgpr_base),
    .wf_init_vgpr_base(wf_init_vgpr_base), .wf_init_lds_base(wf_init_lds_base),
    .issue_wf_done_en(issue_wf_done_en), .issue_wf_done_wfid(issue_wf_done_wfid),
    .wave_ins_half_rqd(wave_ins_half_rqd), .wave_ins_half_wfid(wave_ins_half_wfid),
    .issue_recover_en(issue_recover_en), .issue_recover_wfid(issue_recover_wfid),
    .wave_instr_valid(wave_instr_valid), .wave_instr(wave_instr), .wave_instr_pc(wave_instr_pc),
    .wave_wfid(wave_wfid), .wave_sgpr_base(wave_sgpr_base), .wave_vgpr_base(wave_vgpr_base),
    .wave_lds_base(wave_lds_base), .wf_buf_full(wf_buf_full), .overflow_err(overflow_err),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] i; logic [31:0] p; } ent_t;
  ent_t mq [8][$];
  bit mblk [8];
  bit mhp [8];
  logic [8:0] msg [8];
  logic [9:0] mvg [8];
  logic [15:0] mld [8];
  int mlast = 7;
  bit movf = 0;
  int missued = 0;
  bit mprev = 0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    fetch_valid = 0; fetch_wfid = 0; fetch_instr = 0; fetch_pc = 0;
    wf_init_en = 0; wf_init_wfid = 0; wf_init_sgpr_base = 0; wf_init_vgpr_base = 0; wf_init_lds_base = 0;
    issue_wf_done_en = 0; issue_wf_done_wfid = 0;
    wave_ins_half_rqd = 0; wave_ins_half_wfid = 0;
    issue_recover_en = 0; issue_recover_wfid = 0;
  endtask

  // Model one cycle from the current inputs, clock the DUT, then compare.
  task automatic cyc();
    int g, w;
    bit hg, pf, ev, rec;
    ent_t e;
    logic [8:0] es;
    logic [9:0] evg;
    logic [15:0] el;
    logic [7:0] ef;
    g = -1; hg = 0; ev = 0; e = '{0, 0}; es = 0; evg = 0; el = 0;
    for (int k = 7; k >= 0; k--) begin
      rec = issue_recover_en && int'(issue_recover_wfid) == k;
      if (mhp[k] && mq[k].size() > 0 && !rec) begin g = k; hg = 1; end
    end
    if (!hg)
      for (int k = 8; k >= 1; k--) begin
        w = (mlast + k) % 8;
        rec = issue_recover_en && int'(issue_recover_wfid) == w;
        if (mq[w].size() > 0 && !mblk[w] && !rec) g = w;
      end
    pf = 0;
    if (fetch_valid && fetch_wfid < 8) begin
      if (mq[fetch_wfid].size() == 4) movf = 1;
      else if (!(issue_recover_en && issue_recover_wfid == fetch_wfid)) pf = 1;
    end
    if (g >= 0) begin
      ev = 1;
      e = mq[g].pop_front();
      es = msg[g]; evg = mvg[g]; el = mld[g];
      if (hg) mhp[g] = 0;
      else begin mblk[g] = 1; mlast = g; end
    end
    if (pf) mq[fetch_wfid].push_back('{fetch_instr, fetch_pc});
    if (issue_wf_done_en && issue_wf_done_wfid < 8) mblk[issue_wf_done_wfid] = 0;
    if (wave_ins_half_rqd && wave_ins_half_wfid < 8) mhp[wave_ins_half_wfid] = 1;
    if (issue_recover_en && issue_recover_wfid < 8) begin
      mq[issue_recover_wfid].delete();
      mblk[issue_recover_wfid] = 0;
      mhp[issue_recover_wfid] = 0;
    end
    if (wf_init_en && wf_init_wfid < 8) begin
      msg[wf_init_wfid] = wf_init_sgpr_base;
      mvg[wf_init_wfid] = wf_init_vgpr_base;
      mld[wf_init_wfid] = wf_init_lds_base;
    end
    @(posedge clk);
    @(negedge clk);
    missued += int'(mprev);
    mprev = ev;
    for (int k = 0; k < 8; k++) ef[k] = mq[k].size() == 4;
    chk("valid", wave_instr_valid, ev);
    if (ev) begin
      chk("wfid", wave_wfid, g);
      chk("instr", wave_instr, e.i);
      chk("pc", wave_instr_pc, e.p);
      chk("bases", {wave_sgpr_base, wave_vgpr_base, wave_lds_base}, {es, evg, el});
    end
    chk("overflow", overflow_err, movf);
    chk("buf_full", wf_buf_full, ef);
`ifdef WAVEPOOL_FEEDER_PERF_EN
    chk("issued_cnt", issued_cnt, missued);
`else
    chk("issued_cnt", issued_cnt, 0);
`endif
    clear_in();
  endtask

  task automatic fetch(input int w, input logic [31:0] i, input logic [31:0] p);
    fetch_valid = 1; fetch_wfid = 6'(w); fetch_instr = i; fetch_pc = p;
    cyc();
  endtask

  task automatic done(input int w);
    issue_wf_done_en = 1; issue_wf_done_wfid = 6'(w);
    cyc();
  endtask

  initial begin
    rst = 0;
    clear_in();
    for (int k = 0; k < 8; k++) begin mblk[k] = 0; mhp[k] = 0; msg[k] = 0; mvg[k] = 0; mld[k] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_valid", wave_instr_valid, 0);
    chk("rst_data", {wave_instr, wave_instr_pc}, 0);
    chk("rst_wfid", wave_wfid, 0);
    chk("rst_bases", {wave_sgpr_base, wave_vgpr_base, wave_lds_base}, 0);
    chk("rst_flags", {wf_buf_full, overflow_err}, 0);
    chk("rst_issued", issued_cnt, 0);
    rst = 1;
    cyc();
    // wf 2 single dword, then blocked until done
    fetch(2, 32'hAAAA0001, 32'h100);
    cyc();
    chk("tp1_valid", wave_instr_valid, 1);
    chk("tp1_wfid", wave_wfid, 2);
    chk("tp1_pc", wave_instr_pc, 32'h100);
    fetch(2, 32'hAAAA0002, 32'h104);
    repeat (4) cyc();
    chk("tp1_blocked", wave_instr_valid, 0);
    done(2);
    cyc();
    chk("tp1_after_done", {wave_instr_valid, wave_wfid}, {1'b1, 6'd2});
    // round robin among 0,1,3; wf 1 and 3 left blocked
    wf_init_en = 1; wf_init_wfid = 0; wf_init_sgpr_base = 9'h1a5; wf_init_vgpr_base = 10'h2c3; wf_init_lds_base = 16'hbeef;
    fetch(0, 32'h0000_0a00, 32'h200);
    fetch(1, 32'h0000_0b00, 32'h300);
    fetch(3, 32'h0000_0c00, 32'h400);
    done(0);
    fetch(0, 32'h0000_0a01, 32'h204);
    repeat (4) cyc();
    // 64-bit instruction on wf 5
    fetch(5, 32'hC000_0000, 32'h500);
    fetch(5, 32'h1234_5678, 32'h504);
    chk("tp3_first", {wave_instr_valid, wave_wfid, wave_instr}, {1'b1, 6'd5, 32'hC000_0000});
    wave_ins_half_rqd = 1; wave_ins_half_wfid = 5;
    cyc();
    cyc();
    chk("tp3_second", {wave_instr_valid, wave_wfid, wave_instr}, {1'b1, 6'd5, 32'h1234_5678});
    repeat (3) cyc();
    // overflow on blocked wf 1
    for (int k = 0; k < 5; k++) fetch(1, 32'h1100_0000 + k, 32'h600 + 4 * k);
    chk("tp4_full", wf_buf_full[1], 1);
    chk("tp4_ovf", overflow_err, 1);
    for (int k = 0; k < 6; k++) done(1);
    repeat (3) cyc();
    // recover wf 3 with queued dwords and a same-cycle write
    for (int k = 0; k < 3; k++) fetch(3, 32'h3300_0000 + k, 32'h700 + 4 * k);
    issue_recover_en = 1; issue_recover_wfid = 3;
    fetch(3, 32'h33FF_FFFF, 32'h7f0);
    done(3);
    repeat (3) cyc();
    chk("tp5_empty", wave_instr_valid, 0);
    fetch(3, 32'h3400_0000, 32'h800);
    cyc();
    chk("tp5_new", {wave_instr_valid, wave_wfid, wave_instr}, {1'b1, 6'd3, 32'h3400_0000});
    // random traffic, including out-of-range wfids
    for (int n = 0; n < 3000; n++) begin
      fetch_valid = $urandom_range(0, 9) < 6;
      fetch_wfid = 6'($urandom_range(0, 8));
      fetch_instr = $urandom;
      fetch_pc = $urandom;
      wf_init_en = $urandom_range(0, 19) == 0;
      wf_init_wfid = 6'($urandom_range(0, 8));
      wf_init_sgpr_base = 9'($urandom);
      wf_init_vgpr_base = 10'($urandom);
      wf_init_lds_base = 16'($urandom);
      issue_wf_done_en = $urandom_range(0, 9) < 4;
      issue_wf_done_wfid = 6'($urandom_range(0, 9));
      wave_ins_half_rqd = $urandom_range(0, 19) < 3;
      wave_ins_half_wfid = 6'($urandom_range(0, 9));
      issue_recover_en = $urandom_range(0, 39) == 0;
      issue_recover_wfid = 6'($urandom_range(0, 8));
      cyc();
    end
    for (int r = 0; r < 6; r++)
      for (int w = 0; w < 8; w++) done(w);
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
